i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- I2S transmitter for the loopback playback path. It reads 32-bit stereo words from the DAC FIFO read port and serialises them onto the codec's BCLK, LRCK and SDATA pins.
- BCLK and LRCK are generated internally from clk_48M using clock-enable counters. No derived clock drives any internal logic.
- It is the transmit counterpart of the ADC capture path, which feeds adcfifo_readdata.

Parameters:
- BCLK_HALF, 8: clk_48M cycles per BCLK half-period. Must be at least 2. Default gives a 3 MHz BCLK and 46.875 kHz LRCK.
- DATA_W, 16: bits per channel. Left is word[31:16], right is word[15:0].
- SLOT_W, 32: BCLK periods per channel slot, so a frame is 64 BCLKs.

Ports:
- clk_48M  in  1  system clock
- rst  in  1  synchronous, active-high reset
- send_en  in  1  playback enable; sampled only at frame boundaries and in IDLE
- mute  in  1  forces transmitted samples to zero at word load
- fifo_empty  in  1  DAC FIFO empty flag
- fifo_rdata  in  32  FIFO read data, valid exactly one clk after fifo_rd_en
- fifo_rd_en  out  1  single-clk read strobe
- dac_bclk  out  1  bit clock, registered
- dac_lrck  out  1  word select, registered; 0 = left
- dac_sdata  out  1  serial data, registered
- sample_tick  out  1  1-clk pulse when a new frame word is loaded
- underrun  out  1  1-clk pulse when a frame loads without fresh data
- underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset: every output is 0; state = IDLE; all counters, pending register and underrun_cnt are cleared. Reset asserted mid-frame takes effect on the next edge with no completion of the frame.
- Timing counters:
  - div_cnt runs 0..BCLK_HALF-1 and toggles bclk on wrap.
  - A falling BCLK edge (bclk 1->0) is fe; a rising edge is re.
  - slot counts 0..63 and advances on each fe.
- States:
  - IDLE: bclk, lrck and sdata are held 0. When send_en=1, go to PRIME.
  - PRIME: if !fifo_empty, pulse rd_en, capture fifo_rdata on the next clk and set pend_valid. Then enter RUN with slot=63 and bclk=1. The first fe therefore performs the slot-0 load.
  - RUN: normal transmission. At a fe entering slot 0, if send_en=0 go to IDLE instead of loading; no partial frames are sent.
- Launch on fe:
  - lrck = slot[5].
  - Slots 1..16 carry left bits 15..0, MSB first. Slot 1 is one BCLK after the LRCK edge, per I2S Philips format.
  - Slots 33..48 carry right bits 15..0.
  - All other slots carry 0.
  - The codec samples SDATA on re.
- Word load on the fe into slot 0:
  - frame_word = (pend_valid && !mute) ? pend : 0. Then pend_valid clears and sample_tick pulses.
  - If !pend_valid: underrun pulses and underrun_cnt increments, saturating at 16'hFFFF.
  - mute does not count as an underrun.
- Prefetch on the fe into slot 60: if !fifo_empty && !pend_valid, pulse fifo_rd_en for one clk. pend captures fifo_rdata on the following clk.
- Empty FIFO at the prefetch point: no read is issued and no retry is made. The next frame becomes an underrun.
- rd_en is never asserted while fifo_empty=1. There is at most one read per frame.
- Simultaneous send_en fall and slot-0 load: the block goes to IDLE, skips the load, and pend is kept for the next start.

Decomposition:
- Shared package i2s_pkg holds:
  - FRAME_SLOTS=64 and the slot constants LEFT_MSB_SLOT=1, RIGHT_MSB_SLOT=33, PREFETCH_SLOT=60;
  - the state enum {IDLE, PRIME, RUN}.
- One sub-module, i2s_clk_gen: the div_cnt/bclk/slot counter. It outputs bclk, fe, re and slot.

Test Plan:
- Reset → all outputs 0.
- send_en=1, FIFO preloaded 32'h8001_7FFE, BCLK_HALF=8:
  - BCLK period is 16 clk.
  - At slot 1, SDATA=1 (left MSB); at slot 16, SDATA=1.
  - Right stream reads 0111_1111_1111_1110.
  - Frame length is 1024 clk.
  - fifo_rd_en pulses once per frame at slot 60.
- FIFO empty for 3 frames:
  - 3 underrun pulses, underrun_cnt=3, SDATA all 0.
  - No fifo_rd_en asserted while empty.
- mute=1 with data 32'hFFFF_FFFF → SDATA 0 in every slot; underrun stays 0; reads continue.
- send_en dropped at slot 20 → the frame completes through slot 63, then IDLE with outputs 0 and no further reads.
- rst asserted at slot 40 for 1 clk → all outputs 0 next clk, underrun_cnt=0, state IDLE.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and state type for the I2S DAC transmitter.
//   FRAME_SLOTS    - BCLK periods per stereo frame (two 32-bit slots)
//   LEFT_MSB_SLOT  - slot carrying the left MSB (one BCLK after the LRCK edge)
//   RIGHT_MSB_SLOT - slot carrying the right MSB
//   PREFETCH_SLOT  - slot whose falling edge issues the next FIFO read
package i2s_pkg;
    localparam int FRAME_SLOTS    = 64;
    localparam int SLOT_BITS      = $clog2(FRAME_SLOTS);
    localparam int LEFT_MSB_SLOT  = 1;
    localparam int RIGHT_MSB_SLOT = 33;
    localparam int PREFETCH_SLOT  = 60;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bit-clock divider and frame slot counter, all clock-enable based.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  hold counters and bclk at 0
//   start in  preset slot to the last slot with bclk high (first fe lands on slot 0)
//   adv   in  run the divider
//   bclk  out registered bit clock
//   fe/re out 1-clk strobes in the cycle before bclk falls / rises
//   slot  out current slot, advances on each fe
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 adv,
    output logic                 bclk,
    output logic                 fe,
    output logic                 re,
    output logic [SLOT_BITS-1:0] slot
);
    localparam int DW = $clog2(BCLK_HALF);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap = (div_cnt == DW'(BCLK_HALF - 1));
    assign fe   = adv && wrap && bclk;
    assign re   = adv && wrap && !bclk;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            slot    <= '0;
        end else if (start) begin
            div_cnt <= '0;
            bclk    <= 1'b1;
            slot    <= SLOT_BITS'(FRAME_SLOTS - 1);
        end else if (adv) begin
            if (wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (bclk) slot <= slot + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S (Philips format) transmitter fed from the DAC FIFO.
//   clk_48M      in  system clock
//   rst          in  synchronous active-high reset
//   send_en      in  playback enable, honoured in IDLE and at frame boundaries
//   mute         in  zero the samples of the word being loaded
//   fifo_empty   in  FIFO empty flag
//   fifo_rdata   in  FIFO data, valid one clk after fifo_rd_en
//   fifo_rd_en   out single-clk read strobe
//   dac_bclk/dac_lrck/dac_sdata out registered codec pins
//   sample_tick  out pulse on each frame word load
//   underrun     out pulse when a frame loads with no fresh word
//   underrun_cnt out saturating underrun count
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 8,
    parameter int DATA_W    = 16,
    parameter int SLOT_W    = 32
) (
    input  logic                clk_48M,
    input  logic                rst,
    input  logic                send_en,
    input  logic                mute,
    input  logic                fifo_empty,
    input  logic [2*DATA_W-1:0] fifo_rdata,
    output logic                fifo_rd_en,
    output logic                dac_bclk,
    output logic                dac_lrck,
    output logic                dac_sdata,
    output logic                sample_tick,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);
    localparam int W = 2 * DATA_W;
    localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(2 * SLOT_W - 1);

    state_t                 state, state_nxt;
    logic                   pend_valid, rd_d, rd_req;
    logic [W-1:0]           pend, frame_word;
    logic                   bclk, fe, re;
    logic [SLOT_BITS-1:0]   slot, ns;
    logic                   load_edge, do_load, stop, tx_bit;
    logic [SLOT_BITS-1:0]   idx;
    logic                   unused_re;

    assign unused_re = re;
    assign ns        = slot + 1'b1;          // slot being entered on this fe
    assign load_edge = (state == RUN) && fe && (slot == LAST_SLOT);
    assign stop      = load_edge && !send_en;
    assign do_load   = load_edge && send_en;

    i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
        .clk   (clk_48M),
        .rst   (rst),
        .clr   (state_nxt != RUN),
        .start (state != RUN && state_nxt == RUN),
        .adv   (state == RUN),
        .bclk  (bclk),
        .fe    (fe),
        .re    (re),
        .slot  (slot)
    );

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            IDLE:  if (send_en) state_nxt = PRIME;
            PRIME: begin
                // A word kept from a stopped run is reused instead of read again.
                if (rd_d)                           state_nxt = RUN;
                else if (!pend_valid && !fifo_empty) rd_req   = 1'b1;
                else                                state_nxt = RUN;
            end
            RUN: begin
                if (stop) state_nxt = IDLE;
                if (fe && ns == SLOT_BITS'(PREFETCH_SLOT) && !pend_valid && !fifo_empty)
                    rd_req = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_rd_en = rd_req && !rst;

    // Bit select for the slot being entered; slots outside both channel
    // windows (including the load slot) send 0.
    always_comb begin
        tx_bit = 1'b0;
        idx    = '0;
        if (ns >= SLOT_BITS'(LEFT_MSB_SLOT) && ns < SLOT_BITS'(LEFT_MSB_SLOT + DATA_W)) begin
            idx    = SLOT_BITS'(LEFT_MSB_SLOT + W - 1) - ns;
            tx_bit = frame_word[idx[$clog2(W)-1:0]];
        end else if (ns >= SLOT_BITS'(RIGHT_MSB_SLOT) && ns < SLOT_BITS'(RIGHT_MSB_SLOT + DATA_W)) begin
            idx    = SLOT_BITS'(RIGHT_MSB_SLOT + DATA_W - 1) - ns;
            tx_bit = frame_word[idx[$clog2(W)-1:0]];
        end
    end

    always_ff @(posedge clk_48M) begin
        if (rst) begin
            state        <= IDLE;
            pend         <= '0;
            pend_valid   <= 1'b0;
            rd_d         <= 1'b0;
            frame_word   <= '0;
            dac_lrck     <= 1'b0;
            dac_sdata    <= 1'b0;
            sample_tick  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state       <= state_nxt;
            rd_d        <= fifo_rd_en;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;

            if (rd_d) begin
                pend       <= fifo_rdata;
                pend_valid <= 1'b1;
            end else if (do_load) begin
                pend_valid <= 1'b0;
            end

            if (do_load) begin
                frame_word  <= (pend_valid && !mute) ? pend : '0;
                sample_tick <= 1'b1;
                if (!pend_valid) begin
                    underrun <= 1'b1;
                    if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
                end
            end

            if (state_nxt != RUN) begin
                dac_lrck  <= 1'b0;
                dac_sdata <= 1'b0;
            end else if (state == RUN && fe) begin
                dac_lrck  <= ns[SLOT_BITS-1];
                dac_sdata <= tx_bit;
            end
        end
    end

    assign dac_bclk = bclk;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed bench for i2s_dac_tx with a behavioural FIFO.
module tb_i2s_dac_tx;
    logic        clk = 1'b0;
    logic        rst, send_en, mute;
    logic        fifo_empty, fifo_rd_en;
    logic [31:0] fifo_rdata = '0;
    logic        dac_bclk, dac_lrck, dac_sdata, sample_tick, underrun;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    i2s_dac_tx #(.BCLK_HALF(8), .DATA_W(16), .SLOT_W(32)) dut (
        .clk_48M(clk), .rst(rst), .send_en(send_en), .mute(mute),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .dac_bclk(dac_bclk), .dac_lrck(dac_lrck), .dac_sdata(dac_sdata),
        .sample_tick(sample_tick), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    // FIFO model: data appears one clk after the read strobe.
    logic [31:0] mem [16];
    int wr_ptr = 0, rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) if (fifo_rd_en) begin
        fifo_rdata <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1;
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    // Monitors: frame period, read count, read position and reads while empty.
    int cyc = 0, last_tick = -100000, last_period = 0;
    int rd_count = 0, rd_off_bad = 0, empty_rd = 0;
    always @(negedge clk) begin
        cyc++;
        if (sample_tick) begin
            last_period = cyc - last_tick;
            last_tick   = cyc;
        end
        if (fifo_rd_en) begin
            rd_count++;
            if (fifo_empty) empty_rd++;
            // Prefetch strobe is in the fe cycle into slot 60: 60*16 clk after
            // the slot-0 fe, i.e. 959 clk after the sample_tick cycle.
            if (cyc - last_tick < 1024 && cyc - last_tick != 959) rd_off_bad++;
        end
    end

    int pass_cnt = 0, chk_cnt = 0;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_rise(output bit ok, output int n);
        n = 0;
        while (dac_bclk !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        while (dac_bclk !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        ok = (n < 40);
    endtask

    task automatic wait_tick(output bit ok);
        int n = 0;
        @(negedge clk);
        while (sample_tick !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
        ok = (n < 1100);
        #1;
    endtask

    // Records SDATA/LRCK at each BCLK rise of one frame; bit k = slot k.
    task automatic capture(input int nrise, input int drop_at,
                           output logic [63:0] sd, output logic [63:0] lr,
                           output bit ok, output int badp);
        bit r; int n;
        ok = 1; badp = 0; sd = '0; lr = '0;
        for (int k = 0; k < nrise; k++) begin
            wait_rise(r, n);
            if (!r) ok = 0;
            if (k > 0 && n != 16) badp++;
            sd[k] = dac_sdata;
            lr[k] = dac_lrck;
            if (k == drop_at) send_en = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] sd, input logic [63:0] lr,
                               input logic [15:0] el, input logic [15:0] er);
        logic [15:0] l, r;
        for (int i = 0; i < 16; i++) begin
            l[15-i] = sd[1+i];
            r[15-i] = sd[33+i];
        end
        check({tag, "_left"},  l, el);
        check({tag, "_right"}, r, er);
        check({tag, "_idle_slots"}, sd & ~64'h0001_FFFE_0001_FFFE, 0);
        check({tag, "_lrck"}, lr, 64'hFFFF_FFFF_0000_0000);
    endtask

    task automatic idle_window(input string tag, input int ncyc);
        int bad = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (dac_bclk || dac_lrck || dac_sdata || sample_tick || fifo_rd_en) bad++;
        end
        check(tag, bad, 0);
    endtask

    typedef struct {
        logic [31:0] word;
        bit          push;
        logic        mute;
        logic [15:0] exp_l, exp_r;
        logic        exp_und;
    } vec_t;

    initial begin
        vec_t vecs[7];
        logic [63:0] sd, lr;
        bit ok; int badp;

        vecs[0] = '{32'h8001_7FFE, 1, 1'b0, 16'h8001, 16'h7FFE, 1'b0};
        vecs[1] = '{32'hA5A5_5A5A, 1, 1'b0, 16'hA5A5, 16'h5A5A, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{32'h0001_8000, 1, 1'b0, 16'h0001, 16'h8000, 1'b0};
        vecs[4] = '{32'h0,         0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{32'h0,         0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{32'h0,         0, 1'b0, 16'h0000, 16'h0000, 1'b1};

        rst = 1'b1; send_en = 1'b0; mute = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pins", {dac_bclk, dac_lrck, dac_sdata, fifo_rd_en}, 0);
        check("reset_pulses", {sample_tick, underrun}, 0);
        check("reset_cnt", underrun_cnt, 0);
        rst = 1'b0;
        idle_window("idle_disabled", 20);

        foreach (vecs[k]) if (vecs[k].push) push(vecs[k].word);
        send_en = 1'b1;

        foreach (vecs[k]) begin
            mute = vecs[k].mute;
            wait_tick(ok);
            check($sformatf("v%0d_tick", k), ok, 1);
            check($sformatf("v%0d_underrun", k), underrun, vecs[k].exp_und);
            if (k > 0) check($sformatf("v%0d_frame_len", k), last_period, 1024);
            capture(64, -1, sd, lr, ok, badp);
            check($sformatf("v%0d_bclk", k), {ok, 31'(badp)}, {1'b1, 31'd0});
            check_frame($sformatf("v%0d", k), sd, lr, vecs[k].exp_l, vecs[k].exp_r);
        end
        check("underrun_cnt_3", underrun_cnt, 3);
        check("reads_table", rd_count, 4);
        mute = 1'b0;

        // Stop at a frame boundary: no load, no extra underrun.
        send_en = 1'b0;
        repeat (40) @(negedge clk);
        idle_window("idle_after_stop", 64);
        check("cnt_after_stop", underrun_cnt, 3);

        // Restart, then drop send_en mid-frame: that frame must still finish.
        push(32'h1234_5678);
        push(32'hCAFE_F00D);
        send_en = 1'b1;
        wait_tick(ok);
        check("w1_tick", {ok, underrun}, 2'b10);
        capture(64, -1, sd, lr, ok, badp);
        check_frame("w1", sd, lr, 16'h1234, 16'h5678);
        wait_tick(ok);
        check("w2_tick", {ok, underrun}, 2'b10);
        capture(64, 20, sd, lr, ok, badp);
        check("w2_bclk", {ok, 31'(badp)}, {1'b1, 31'd0});
        check_frame("w2", sd, lr, 16'hCAFE, 16'hF00D);
        repeat (20) @(negedge clk);
        push(32'h0F0F_F0F0);
        idle_window("idle_after_drop", 1100);
        check("reads_idle", rd_count, 6);

        // Reset in the middle of a frame.
        send_en = 1'b1;
        wait_tick(ok);
        check("w3_tick", ok, 1);
        capture(41, -1, sd, lr, ok, badp);
        check("w3_left", sd[16:1], 16'hF0F0);
        rst = 1'b1; send_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_pins", {dac_bclk, dac_lrck, dac_sdata, fifo_rd_en, sample_tick, underrun}, 0);
        check("midrst_cnt", underrun_cnt, 0);
        idle_window("idle_after_rst", 64);
        check("reads_total", rd_count, 7);
        check("reads_while_empty", empty_rd, 0);
        check("read_position", rd_off_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
